// File: rtl/rotate_req_arbiter_pkg.sv
// Shared types and constants for the rotate request arbiter.
// Holds the FSM state encoding, datapath widths, the captured-operand payload
// and the rotate-left to rotate-right amount conversion.
package rotate_req_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Operand as presented to the rotate-right unit
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } rot_op_t;

  // Rotate left by n equals rotate right by (32 - n) mod 32; 5-bit wrap handles n = 0
  function automatic logic [AMT_W-1:0] right_amt(input logic [AMT_W-1:0] amt,
                                                 input logic             left);
    return left ? AMT_W'(~amt + AMT_W'(1)) : amt;
  endfunction

endpackage

// File: rtl/rotate_right_32_bit.sv
// Combinational 32-bit rotate-right unit.
// Ports: data - operand, amt - rotate-right amount (0..31), result - rotated operand.
module rotate_right_32_bit
  import rotate_req_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result
);

  // Shifting the doubled word right leaves the rotated value in the low half
  assign result = DATA_W'({data, data} >> amt);

endmodule

// File: rtl/rotate_req_arbiter.sv
// Round-robin arbiter sharing one rotate-right unit between two requesters.
// Ports:
//   clock, clear      - clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready  - request handshake per requester (ready is combinational)
//   reqN_data/amt/left- operand, rotate amount, direction (1 = left)
//   rsp_valid/ready   - registered result handshake
//   rsp_data, rsp_id  - rotated result and owning requester
//   busy              - operation in flight (state is not IDLE)
module rotate_req_arbiter
  import rotate_req_arbiter_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_left,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_left,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  busy
);

  state_t            state_q, state_d;
  rot_op_t           op_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              can_grant_c;
  logic              win1_c;
  logic              grant_c;
  logic              capture_en;
  logic              exec_en;
  logic              release_en;
  logic [DATA_W-1:0] rot_c;

  // A new grant is possible when idle or when the held result leaves this cycle;
  // clear gates it so no ready is issued while in reset
  assign can_grant_c = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
  assign grant_c     = clear && can_grant_c && (req0_valid || req1_valid);
  // On a tie the requester that did not win last time gets the grant
  assign win1_c      = req1_valid && (!req0_valid || !last_grant_q);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_c) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = grant_c ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request readies and datapath enables
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    capture_en = 1'b0;
    exec_en    = 1'b0;
    release_en = 1'b0;
    if (grant_c) begin
      req0_ready = !win1_c;
      req1_ready = win1_c;
      capture_en = 1'b1;
    end
    if (state_q == EXEC) exec_en = 1'b1;
    if ((state_q == HOLD) && rsp_ready) release_en = 1'b1;
  end

  assign busy = (state_q != IDLE);

  // Capture the granted operand, converted to a right-rotate amount
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= ~1'(RESET_PRIO);
    end else if (capture_en) begin
      op_q.data    <= win1_c ? req1_data : req0_data;
      op_q.amt     <= win1_c ? right_amt(req1_amt, req1_left)
                             : right_amt(req0_amt, req0_left);
      owner_q      <= win1_c;
      last_grant_q <= win1_c;
    end
  end

  rotate_right_32_bit u_rotate (
    .data   (op_q.data),
    .amt    (op_q.amt),
    .result (rot_c)
  );

  // Result register: loaded in EXEC, held until the consumer takes it
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (exec_en) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rot_c;
      rsp_id    <= owner_q;
    end else if (release_en) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotate_req_arbiter.sv
// Self-checking bench for rotate_req_arbiter: directed scenarios followed by a
// randomized regression against a bit-level rotate model and transaction queue.
module tb_rotate_req_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic        req0_valid, req0_ready, req0_left;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_left;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  rotate_req_arbiter #(.RESET_PRIO(0)) dut (
    .clock      (clock),
    .clear      (clear),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_left  (req0_left),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_left  (req1_left),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  // Reference rotate: move each source bit to its destination position
  function automatic logic [31:0] ref_rot(input logic [31:0] d, input int amt, input bit left);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      int dst;
      dst = left ? (i + amt) % 32 : (i - amt + 32) % 32;
      r[dst] = d[i];
    end
    return r;
  endfunction

  // One isolated operation with rsp_ready held high
  task automatic single(input string tag, input bit id, input logic [31:0] d,
                        input logic [4:0] amt, input bit left, input logic [31:0] exp);
    next();
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = amt; req1_left = left;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = amt; req0_left = left;
    end
    #1;
    chk1({tag, "_ready0"}, req0_ready, !id);
    chk1({tag, "_ready1"}, req1_ready, id);
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk1({tag, "_exec_valid"}, rsp_valid, 1'b0);
    chk1({tag, "_exec_busy"}, busy, 1'b1);
    next();
    chk1({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_data"}, rsp_data, exp);
    chk1({tag, "_id"}, rsp_id, id);
    next();
    chk1({tag, "_drop"}, rsp_valid, 1'b0);
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  logic [31:0] rd [2];
  logic [4:0]  ra [2];
  bit          rl [2];
  bit          rv [2];
  logic [32:0] exp_q [$];

  initial begin
    bit pend, exp_rv, can, g, w, mlast;
    int age, ops, cyc, diff;

    clear = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_amt = '0; req0_left = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_left = 1'b0;
    rsp_ready = 1'b0;

    // Reset state, and no ready while clear is low even with a request pending
    req0_valid = 1'b1;
    #12;
    chk1("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, 32'h0);
    chk1("rst_id", rsp_id, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    req0_valid = 1'b0;
    @(negedge clock) clear = 1'b1;

    single("ror1", 1'b0, 32'h8000_0001, 5'd1, 1'b0, 32'hC000_0000);
    single("rol4", 1'b1, 32'h8000_0001, 5'd4, 1'b1, 32'h0000_0018);
    single("rol0", 1'b1, 32'h1234_5678, 5'd0, 1'b1, 32'h1234_5678);
    single("ror0", 1'b0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);

    // Tie from reset: requester 0 first, requester 1 back-to-back
    @(negedge clock) clear = 1'b0;
    @(negedge clock) clear = 1'b1;
    next();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h0000_000F; req0_amt = 5'd4; req0_left = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_000F; req1_amt = 5'd4; req1_left = 1'b0;
    #1;
    chk1("tie_ready0", req0_ready, 1'b1);
    chk1("tie_ready1", req1_ready, 1'b0);
    next();
    req0_valid = 1'b0;
    #1;
    chk1("tie_exec_ready1", req1_ready, 1'b0);
    chk1("tie_exec_valid", rsp_valid, 1'b0);
    next();
    chk1("tie_first_valid", rsp_valid, 1'b1);
    chk1("tie_first_id", rsp_id, 1'b0);
    chk("tie_first_data", rsp_data, 32'hF000_0000);
    chk1("tie_b2b_ready1", req1_ready, 1'b1);
    next();
    req1_valid = 1'b0;
    #1;
    chk1("tie_b2b_exec_valid", rsp_valid, 1'b0);
    chk1("tie_b2b_busy", busy, 1'b1);
    next();
    chk1("tie_second_valid", rsp_valid, 1'b1);
    chk1("tie_second_id", rsp_id, 1'b1);
    chk("tie_second_data", rsp_data, 32'hF000_0000);
    next();
    chk1("tie_done", busy, 1'b0);

    // Stall: result held 5 cycles while requester 1 waits
    next();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 5'd1; req0_left = 1'b1;
    req1_valid = 1'b1; req1_data = 32'hDEAD_BEEF; req1_amt = 5'd8; req1_left = 1'b0;
    #1;
    chk1("stall_ready0", req0_ready, 1'b1);
    chk1("stall_ready1", req1_ready, 1'b0);
    next();
    req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next();
      chk1("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, 32'h0000_0002);
      chk1("stall_id", rsp_id, 1'b0);
      chk1("stall_hold_ready1", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk1("stall_release_ready1", req1_ready, 1'b1);
    chk1("stall_release_ready0", req0_ready, 1'b0);
    next();
    req1_valid = 1'b0;
    #1;
    chk1("stall_b2b_valid", rsp_valid, 1'b0);
    next();
    chk1("stall_r1_valid", rsp_valid, 1'b1);
    chk("stall_r1_data", rsp_data, 32'hEFDE_ADBE);
    chk1("stall_r1_id", rsp_id, 1'b1);
    next();
    chk1("stall_done", rsp_valid, 1'b0);

    // Reset during EXEC discards the in-flight result
    next();
    req0_valid = 1'b1; req0_data = 32'h1111_1111; req0_amt = 5'd3; req0_left = 1'b0;
    #1;
    chk1("abort_ready0", req0_ready, 1'b1);
    next();
    chk1("abort_exec_busy", busy, 1'b1);
    #1;
    clear = 1'b0;
    #1;
    chk1("abort_valid", rsp_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_data", rsp_data, 32'h0);
    chk1("abort_ready0_in_reset", req0_ready, 1'b0);
    req0_valid = 1'b0;
    @(negedge clock) clear = 1'b1;
    single("ror31", 1'b0, 32'hA5A5_A5A5, 5'd31, 1'b0, 32'h4B4B_4B4B);

    // Random regression; the last grant above went to requester 0
    pend = 1'b0; age = 0; ops = 0; cyc = 0; diff = 0; mlast = 1'b0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    while (ops < 10000 && cyc < 60000) begin
      next();
      cyc++;
      if (pend) age++;
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && $urandom_range(0, 3) != 0) begin
          rv[i] = 1'b1;
          rd[i] = $urandom;
          ra[i] = 5'($urandom_range(0, 31));
          rl[i] = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_valid = rv[0]; req0_data = rd[0]; req0_amt = ra[0]; req0_left = rl[0];
      req1_valid = rv[1]; req1_data = rd[1]; req1_amt = ra[1]; req1_left = rl[1];
      #1;
      // Unit is free when nothing is outstanding or the held result leaves now
      exp_rv = pend && (age >= 2);
      can    = !pend || (exp_rv && rsp_ready);
      g      = can && (rv[0] || rv[1]);
      w      = (rv[0] && rv[1]) ? !mlast : rv[1];
      chk1("rnd_ready0", req0_ready, g && !w);
      chk1("rnd_ready1", req1_ready, g && w);
      chk1("rnd_valid", rsp_valid, exp_rv);
      if (exp_rv && exp_q.size() > 0) begin
        chk("rnd_data", rsp_data, exp_q[0][31:0]);
        chk1("rnd_id", rsp_id, exp_q[0][32]);
      end
      if (rv[0] && rv[1]) begin
        if (req0_ready) diff++;
        if (req1_ready) diff--;
        chk1("rnd_fair", (diff <= 1) && (diff >= -1), 1'b1);
      end else begin
        diff = 0;
      end
      if (exp_rv && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pend = 1'b0;
        ops++;
      end
      if (g) begin
        exp_q.push_back({w, ref_rot(rd[w], int'(ra[w]), rl[w])});
        pend  = 1'b1;
        age   = 0;
        mlast = w;
        rv[w] = 1'b0;
      end
    end
    chk1("rnd_ops_completed", ops >= 10000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
